// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority vote per bit, optional parity, 1..2 stop
// bits, and a one-entry holding register with valid/ack and overrun detection.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 4,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ack,
  output logic                 perr,
  output logic                 ferr,
  output logic                 overrun,
  output logic                 busy
);

  localparam int STEP_W = $clog2(OVERSAMPLE);
  localparam int ONES_W = $clog2(OVERSAMPLE + 1);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(OVERSAMPLE - 1);
  localparam logic [ONES_W:0]   VOTE_THR  = (ONES_W + 1)'(OVERSAMPLE);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PAR       = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  logic                 sync1_q, sync2_q;
  state_t               state_q;
  logic [STEP_W-1:0]    step_q;
  logic [ONES_W-1:0]    ones_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_f_q, ferr_f_q, deliver_q, busy_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q, overrun_q;

  logic [ONES_W-1:0]    ones_d;
  logic                 last_d, vote_d, par_err_d, ferr_d;

  // Two-flop synchroniser; idles high so reset cannot look like a start bit.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= UART_RX;
      sync2_q <= sync1_q;
    end
  end

  // Vote includes the current sample so a period resolves on its last sample.
  always_comb begin
    ones_d    = ones_q + {{(ONES_W-1){1'b0}}, sync2_q};
    last_d    = (step_q == STEP_LAST);
    vote_d    = ({ones_d, 1'b0} > VOTE_THR);
    par_err_d = (PARITY == 1) ? ~(^shift_q ^ vote_d) : (^shift_q ^ vote_d);
    ferr_d    = ferr_f_q | ~vote_d;
  end

  // Frame FSM: the step/ones pair is reused for every bit period.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      ones_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      perr_f_q  <= 1'b0;
      ferr_f_q  <= 1'b0;
      deliver_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      deliver_q <= 1'b0;
      step_q    <= last_d ? '0 : step_q + STEP_ONE;
      ones_q    <= last_d ? '0 : ones_d;
      case (state_q)
        S_IDLE: begin
          ones_q <= '0;
          bit_q  <= '0;
          if (!sync2_q) begin
            state_q  <= S_START;
            step_q   <= STEP_ONE;
            perr_f_q <= 1'b0;
            ferr_f_q <= 1'b0;
            busy_q   <= 1'b1;
          end else begin
            step_q <= '0;
            busy_q <= 1'b0;
          end
        end
        S_START: begin
          if (last_d) begin
            if (vote_d) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (last_d) begin
            shift_q <= {vote_d, shift_q[DATA_BITS-1:1]};
            if (bit_q == DATA_LAST) begin
              bit_q   <= '0;
              state_q <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_q <= bit_q + BIT_ONE;
            end
          end
        end
        S_PAR: begin
          if (last_d) begin
            perr_f_q <= par_err_d;
            state_q  <= S_STOP;
          end
        end
        S_STOP: begin
          if (last_d) begin
            ferr_f_q <= ferr_d;
            if (bit_q == STOP_LAST) begin
              bit_q     <= '0;
              deliver_q <= 1'b1;
              state_q   <= ferr_d ? S_WAIT_HIGH : S_IDLE;
            end else begin
              bit_q <= bit_q + BIT_ONE;
            end
          end
        end
        S_WAIT_HIGH: begin
          step_q <= '0;
          ones_q <= '0;
          busy_q <= 1'b0;
          if (sync2_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          step_q  <= '0;
          ones_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register; an ack in the delivery cycle consumes the old word.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else if (deliver_q) begin
      data_q    <= shift_q;
      perr_q    <= perr_f_q;
      ferr_q    <= ferr_f_q;
      valid_q   <= 1'b1;
      overrun_q <= valid_q & ~ack;
    end else if (valid_q && ack) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign perr    = perr_q;
  assign ferr    = ferr_q;
  assign overrun = overrun_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: instances for default 8N1, even parity,
// odd parity and two stop bits, all at 4 samples per bit.
module tb_uart_rx_os;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic line   = 1'b1;
  logic ack    = 1'b0;
  int   sel    = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic       rx0, rx1, rx2, rx3;
  logic       ack0, ack1, ack2, ack3;
  logic [7:0] data0, data1, data2, data3;
  logic       valid0, valid1, valid2, valid3;
  logic       perr0, perr1, perr2, perr3;
  logic       ferr0, ferr1, ferr2, ferr3;
  logic       ovr0, ovr1, ovr2, ovr3;
  logic       busy0, busy1, busy2, busy3;

  always #5 clock = ~clock;

  assign rx0  = (sel == 0) ? line : 1'b1;
  assign rx1  = (sel == 1) ? line : 1'b1;
  assign rx2  = (sel == 2) ? line : 1'b1;
  assign rx3  = (sel == 3) ? line : 1'b1;
  assign ack0 = (sel == 0) ? ack : 1'b0;
  assign ack1 = (sel == 1) ? ack : 1'b0;
  assign ack2 = (sel == 2) ? ack : 1'b0;
  assign ack3 = (sel == 3) ? ack : 1'b0;

  uart_rx_os u_def (
    .clock(clock), .resetn(resetn), .UART_RX(rx0), .data(data0), .valid(valid0),
    .ack(ack0), .perr(perr0), .ferr(ferr0), .overrun(ovr0), .busy(busy0));

  uart_rx_os #(.PARITY(2)) u_even (
    .clock(clock), .resetn(resetn), .UART_RX(rx1), .data(data1), .valid(valid1),
    .ack(ack1), .perr(perr1), .ferr(ferr1), .overrun(ovr1), .busy(busy1));

  uart_rx_os #(.PARITY(1)) u_odd (
    .clock(clock), .resetn(resetn), .UART_RX(rx2), .data(data2), .valid(valid2),
    .ack(ack2), .perr(perr2), .ferr(ferr2), .overrun(ovr2), .busy(busy2));

  uart_rx_os #(.STOP_BITS(2)) u_s2 (
    .clock(clock), .resetn(resetn), .UART_RX(rx3), .data(data3), .valid(valid3),
    .ack(ack3), .perr(perr3), .ferr(ferr3), .overrun(ovr3), .busy(busy3));

  // Frame bit k (bit 0 = start) is driven for 4 samples; cmask forces samples of bit cbit low.
  task automatic send_frame(input logic [15:0] bits, input int nbits, input int cbit,
                            input logic [3:0] cmask);
    for (int k = 0; k < nbits; k++) begin
      for (int s = 0; s < 4; s++) begin
        @(negedge clock);
        line = bits[k] & ~((k == cbit) && cmask[s]);
      end
    end
  endtask

  task automatic hold(input logic v, input int n);
    repeat (n) begin
      @(negedge clock);
      line = v;
    end
  endtask

  task automatic idle(input int n);
    hold(1'b1, n);
  endtask

  task automatic pulse_ack();
    @(negedge clock);
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_checks++; if (data0 !== 8'h00) $display("FAIL rst_data: got %h exp 00", data0); else n_pass++;
    n_checks++; if (valid0 !== 1'b0) $display("FAIL rst_valid: got %b exp 0", valid0); else n_pass++;
    n_checks++; if ({perr0, ferr0, ovr0, busy0} !== 4'b0000) $display("FAIL rst_flags: got %b exp 0000", {perr0, ferr0, ovr0, busy0}); else n_pass++;
    n_checks++; if (valid3 !== 1'b0) $display("FAIL rst_valid_s2: got %b exp 0", valid3); else n_pass++;
    @(negedge clock);
    resetn = 1'b1;
    idle(4);
  endtask

  task automatic test_clean_frame();
    sel = 0;
    send_frame({6'd0, 1'b1, 8'hA5, 1'b0}, 10, -1, 4'b0000);
    idle(3);
    n_checks++; if (valid0 !== 1'b0) $display("FAIL a5_valid_early: got %b exp 0", valid0); else n_pass++;
    n_checks++; if (busy0 !== 1'b1) $display("FAIL a5_busy_delivery: got %b exp 1", busy0); else n_pass++;
    idle(1);
    n_checks++; if (valid0 !== 1'b1) $display("FAIL a5_valid: got %b exp 1", valid0); else n_pass++;
    n_checks++; if (data0 !== 8'hA5) $display("FAIL a5_data: got %h exp a5", data0); else n_pass++;
    n_checks++; if ({perr0, ferr0, ovr0, busy0} !== 4'b0000) $display("FAIL a5_flags: got %b exp 0000", {perr0, ferr0, ovr0, busy0}); else n_pass++;
    idle(10);
    n_checks++; if (valid0 !== 1'b1) $display("FAIL a5_valid_hold: got %b exp 1", valid0); else n_pass++;
    pulse_ack();
    n_checks++; if (valid0 !== 1'b0) $display("FAIL a5_ack_valid: got %b exp 0", valid0); else n_pass++;
    n_checks++; if (data0 !== 8'hA5) $display("FAIL a5_ack_data: got %h exp a5", data0); else n_pass++;
    idle(4);
  endtask

  task automatic test_majority();
    sel = 0;
    send_frame({6'd0, 1'b1, 8'h3C, 1'b0}, 10, 3, 4'b0010);
    idle(4);
    n_checks++; if (data0 !== 8'h3C) $display("FAIL vote_one_bad: got %h exp 3c", data0); else n_pass++;
    n_checks++; if (valid0 !== 1'b1) $display("FAIL vote_one_valid: got %b exp 1", valid0); else n_pass++;
    pulse_ack();
    idle(4);
    send_frame({6'd0, 1'b1, 8'h3C, 1'b0}, 10, 4, 4'b0011);
    idle(4);
    n_checks++; if (data0 !== 8'h34) $display("FAIL vote_tie: got %h exp 34", data0); else n_pass++;
    n_checks++; if (ferr0 !== 1'b0) $display("FAIL vote_tie_ferr: got %b exp 0", ferr0); else n_pass++;
    pulse_ack();
    idle(4);
  endtask

  task automatic test_glitch();
    sel = 0;
    hold(1'b0, 1);
    idle(3);
    n_checks++; if (busy0 !== 1'b1) $display("FAIL glitch_busy_start: got %b exp 1", busy0); else n_pass++;
    idle(3);
    n_checks++; if (busy0 !== 1'b0) $display("FAIL glitch_busy_end: got %b exp 0", busy0); else n_pass++;
    idle(50);
    n_checks++; if (valid0 !== 1'b0) $display("FAIL glitch_valid: got %b exp 0", valid0); else n_pass++;
    n_checks++; if ({perr0, ferr0, ovr0} !== 3'b000) $display("FAIL glitch_flags: got %b exp 000", {perr0, ferr0, ovr0}); else n_pass++;
  endtask

  task automatic test_parity();
    sel = 1;
    send_frame({5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, 4'b0000);
    idle(4);
    n_checks++; if ({valid1, data1} !== {1'b1, 8'h07}) $display("FAIL even_p1_word: got %b/%h exp 1/07", valid1, data1); else n_pass++;
    n_checks++; if (perr1 !== 1'b0) $display("FAIL even_p1_perr: got %b exp 0", perr1); else n_pass++;
    pulse_ack();
    send_frame({5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, 4'b0000);
    idle(4);
    n_checks++; if (perr1 !== 1'b1) $display("FAIL even_p0_perr: got %b exp 1", perr1); else n_pass++;
    pulse_ack();
    sel = 2;
    send_frame({5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, 4'b0000);
    idle(4);
    n_checks++; if ({valid2, data2} !== {1'b1, 8'h07}) $display("FAIL odd_p1_word: got %b/%h exp 1/07", valid2, data2); else n_pass++;
    n_checks++; if (perr2 !== 1'b1) $display("FAIL odd_p1_perr: got %b exp 1", perr2); else n_pass++;
    pulse_ack();
    send_frame({5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, 4'b0000);
    idle(4);
    n_checks++; if (perr2 !== 1'b0) $display("FAIL odd_p0_perr: got %b exp 0", perr2); else n_pass++;
    pulse_ack();
    idle(4);
  endtask

  task automatic test_framing();
    sel = 3;
    send_frame({5'd0, 1'b0, 1'b1, 8'h5A, 1'b0}, 11, -1, 4'b0000);
    hold(1'b0, 4);
    n_checks++; if ({valid3, data3} !== {1'b1, 8'h5A}) $display("FAIL stop2_word: got %b/%h exp 1/5a", valid3, data3); else n_pass++;
    n_checks++; if ({ferr3, perr3} !== 2'b10) $display("FAIL stop2_ferr: got %b exp 10", {ferr3, perr3}); else n_pass++;
    pulse_ack();
    hold(1'b0, 50);
    n_checks++; if (busy3 !== 1'b0) $display("FAIL stuck_low_busy: got %b exp 0", busy3); else n_pass++;
    n_checks++; if (valid3 !== 1'b0) $display("FAIL stuck_low_valid: got %b exp 0", valid3); else n_pass++;
    idle(8);
    send_frame({5'd0, 1'b1, 1'b1, 8'h55, 1'b0}, 11, -1, 4'b0000);
    idle(4);
    n_checks++; if ({valid3, data3} !== {1'b1, 8'h55}) $display("FAIL recover_word: got %b/%h exp 1/55", valid3, data3); else n_pass++;
    n_checks++; if (ferr3 !== 1'b0) $display("FAIL recover_ferr: got %b exp 0", ferr3); else n_pass++;
    pulse_ack();
    idle(4);
  endtask

  task automatic test_back_to_back();
    sel = 0;
    send_frame({6'd0, 1'b1, 8'h11, 1'b0}, 10, -1, 4'b0000);
    send_frame({6'd0, 1'b1, 8'h22, 1'b0}, 10, -1, 4'b0000);
    idle(3);
    n_checks++; if ({valid0, data0, ovr0} !== {1'b1, 8'h11, 1'b0}) $display("FAIL b2b_first: got %b/%h/%b exp 1/11/0", valid0, data0, ovr0); else n_pass++;
    idle(1);
    n_checks++; if (data0 !== 8'h22) $display("FAIL b2b_second_data: got %h exp 22", data0); else n_pass++;
    n_checks++; if ({valid0, ovr0} !== 2'b11) $display("FAIL b2b_overrun: got %b exp 11", {valid0, ovr0}); else n_pass++;
    pulse_ack();
    n_checks++; if ({valid0, ovr0} !== 2'b00) $display("FAIL b2b_ack_clear: got %b exp 00", {valid0, ovr0}); else n_pass++;
    idle(4);
    send_frame({6'd0, 1'b1, 8'h11, 1'b0}, 10, -1, 4'b0000);
    send_frame({6'd0, 1'b1, 8'h22, 1'b0}, 10, -1, 4'b0000);
    idle(2);
    @(negedge clock);
    line = 1'b1;
    ack  = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    n_checks++; if ({valid0, data0} !== {1'b1, 8'h22}) $display("FAIL ack_delivery_word: got %b/%h exp 1/22", valid0, data0); else n_pass++;
    n_checks++; if (ovr0 !== 1'b0) $display("FAIL ack_delivery_overrun: got %b exp 0", ovr0); else n_pass++;
    idle(4);
  endtask

  task automatic test_reset_midframe();
    sel = 0;
    send_frame({6'd0, 1'b1, 8'h5A, 1'b0}, 5, -1, 4'b0000);
    n_checks++; if (busy0 !== 1'b1) $display("FAIL mid_busy: got %b exp 1", busy0); else n_pass++;
    #2 resetn = 1'b0;
    #1;
    n_checks++; if ({valid0, data0} !== {1'b0, 8'h00}) $display("FAIL mid_rst_word: got %b/%h exp 0/00", valid0, data0); else n_pass++;
    n_checks++; if ({perr0, ferr0, ovr0, busy0} !== 4'b0000) $display("FAIL mid_rst_flags: got %b exp 0000", {perr0, ferr0, ovr0, busy0}); else n_pass++;
    @(negedge clock);
    resetn = 1'b1;
    line   = 1'b1;
    idle(60);
    n_checks++; if ({valid0, busy0} !== 2'b00) $display("FAIL mid_no_partial: got %b exp 00", {valid0, busy0}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_majority();
    test_glitch();
    test_parity();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
